dac_pulse_sequencer: RTL and testbench

Triggered trapezoidal pulse generator feeding one DAC write channel: on a trigger it streams a ramp-up, flat-top, ramp-down sample sequence in two's complement, one sample per accepted cycle. It sits directly upstream of the DAC channel writer. `out_data`/`out_valid` drive its `in_data`/`in_valid`, and its `out_ready` drives `in_ready`. Runs in the DAC data clock domain.

---
 rtl/dac_pulse_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_dac_pulse_sequencer.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_pulse_sequencer.sv
// Triggered trapezoidal pulse generator feeding one DAC write channel.
// Define DAC_PULSE_SEQUENCER_REPEAT_EN to build the repeat/gap sequencing.
module dac_pulse_sequencer #(
    parameter int INT_DAC_DATA_WIDTH = 14,
    parameter int INT_CNT_WIDTH      = 16
) (
    input  logic                          in_clk,
    input  logic                          in_rst_n,
    input  logic                          in_trigger,
    input  logic [INT_DAC_DATA_WIDTH-1:0] in_cfg_amplitude,
    input  logic [INT_DAC_DATA_WIDTH-1:0] in_cfg_step,
    input  logic [INT_CNT_WIDTH-1:0]      in_cfg_hold,
    input  logic [INT_CNT_WIDTH-1:0]      in_cfg_gap,
    input  logic [7:0]                    in_cfg_repeat,
    input  logic                          in_ready,
    output logic [INT_DAC_DATA_WIDTH-1:0] out_data,
    output logic                          out_valid,
    output logic                          out_busy,
    output logic                          out_done,
    output logic                          out_trig_err
);

    localparam int W = INT_DAC_DATA_WIDTH;
    localparam int C = INT_CNT_WIDTH;
    localparam logic [C-1:0] CNT_ONE  = {{(C-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] STEP_ONE = {{(W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE,
        RISE,
        HOLD,
`ifdef DAC_PULSE_SEQUENCER_REPEAT_EN
        FALL,
        GAP
`else
        FALL
`endif
    } state_t;

    state_t            state_q, state_n;
    logic signed [W:0] level_q, level_n;
    logic [W-1:0]      amp_q, amp_n;
    logic [W-1:0]      step_q, step_n;
    logic [C-1:0]      hold_q, hold_n;
    logic [C-1:0]      cnt_q, cnt_n;
`ifdef DAC_PULSE_SEQUENCER_REPEAT_EN
    logic [C-1:0]      gap_q, gap_n;
    logic [7:0]        rep_q, rep_n;
`else
    logic              unused_cfg;
    assign unused_cfg = ^{in_cfg_gap, in_cfg_repeat};
`endif
    logic              done_n, err_n, busy_n;

    logic [W-1:0]      step_in;
    logic signed [W:0] r_target;
    logic [W-1:0]      r_step;
    logic signed [W:0] r_diff;
    logic [W:0]        r_mag;
    logic              r_hit;
    logic signed [W:0] r_next;

    assign step_in  = (in_cfg_step == '0) ? STEP_ONE : in_cfg_step;
    assign out_data = level_q[W-1:0];

    // One clamped ramp step toward the target; the IDLE case uses the live
    // config so the first ramp sample leaves on the accepting edge.
    always_comb begin
        r_target = '0;
        r_step   = step_q;
        if (state_q == IDLE) begin
            r_target = {in_cfg_amplitude[W-1], in_cfg_amplitude};
            r_step   = step_in;
        end else if (state_q == RISE) begin
            r_target = {amp_q[W-1], amp_q};
        end
        r_diff = r_target - level_q;
        r_mag  = r_diff[W] ? $unsigned(-r_diff) : $unsigned(r_diff);
        r_hit  = (r_mag <= {1'b0, r_step});
        if (r_hit)
            r_next = r_target;
        else if (r_diff[W])
            r_next = level_q - $signed({1'b0, r_step});
        else
            r_next = level_q + $signed({1'b0, r_step});
    end

    always_comb begin
        state_n = state_q;
        level_n = level_q;
        amp_n   = amp_q;
        step_n  = step_q;
        hold_n  = hold_q;
        cnt_n   = cnt_q;
`ifdef DAC_PULSE_SEQUENCER_REPEAT_EN
        gap_n   = gap_q;
        rep_n   = rep_q;
`endif
        done_n  = 1'b0;
        err_n   = in_trigger && (state_q != IDLE);
        busy_n  = (state_q != IDLE);
        if (in_ready) begin
            case (state_q)
                IDLE: begin
                    if (in_trigger) begin
                        amp_n  = in_cfg_amplitude;
                        step_n = step_in;
                        hold_n = in_cfg_hold;
`ifdef DAC_PULSE_SEQUENCER_REPEAT_EN
                        gap_n  = in_cfg_gap;
                        rep_n  = in_cfg_repeat;
`endif
                        if (in_cfg_amplitude == '0) begin
                            done_n = 1'b1;
                        end else begin
                            busy_n  = 1'b1;
                            level_n = r_next;
                            cnt_n   = in_cfg_hold;
                            if (!r_hit)
                                state_n = RISE;
                            else if (in_cfg_hold != '0)
                                state_n = HOLD;
                            else
                                state_n = FALL;
                        end
                    end
                end
                RISE: begin
                    level_n = r_next;
                    cnt_n   = hold_q;
                    if (r_hit)
                        state_n = (hold_q != '0) ? HOLD : FALL;
                end
                HOLD: begin
                    if (cnt_q <= CNT_ONE)
                        state_n = FALL;
                    else
                        cnt_n = cnt_q - CNT_ONE;
                end
                FALL: begin
                    level_n = r_next;
                    if (r_hit) begin
`ifdef DAC_PULSE_SEQUENCER_REPEAT_EN
                        if (rep_q != 8'd0) begin
                            rep_n = rep_q - 8'd1;
                            if (gap_q != '0) begin
                                state_n = GAP;
                                cnt_n   = gap_q;
                            end else begin
                                state_n = RISE;
                            end
                        end else
`endif
                        begin
                            state_n = IDLE;
                            done_n  = 1'b1;
                        end
                    end
                end
`ifdef DAC_PULSE_SEQUENCER_REPEAT_EN
                GAP: begin
                    if (cnt_q <= CNT_ONE)
                        state_n = RISE;
                    else
                        cnt_n = cnt_q - CNT_ONE;
                end
`endif
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge in_clk) begin
        if (!in_rst_n) begin
            state_q      <= IDLE;
            level_q      <= '0;
            amp_q        <= '0;
            step_q       <= '0;
            hold_q       <= '0;
            cnt_q        <= '0;
`ifdef DAC_PULSE_SEQUENCER_REPEAT_EN
            gap_q        <= '0;
            rep_q        <= '0;
`endif
            out_valid    <= 1'b0;
            out_busy     <= 1'b0;
            out_done     <= 1'b0;
            out_trig_err <= 1'b0;
        end else begin
            state_q      <= state_n;
            level_q      <= level_n;
            amp_q        <= amp_n;
            step_q       <= step_n;
            hold_q       <= hold_n;
            cnt_q        <= cnt_n;
`ifdef DAC_PULSE_SEQUENCER_REPEAT_EN
            gap_q        <= gap_n;
            rep_q        <= rep_n;
`endif
            out_valid    <= 1'b1;
            out_busy     <= busy_n;
            out_done     <= done_n;
            out_trig_err <= err_n;
        end
    end

endmodule

// File: tb/tb_dac_pulse_sequencer.sv
// Self-checking bench for dac_pulse_sequencer against a sample-list model.
// Expectations follow DAC_PULSE_SEQUENCER_REPEAT_EN when it is defined.
module tb_dac_pulse_sequencer;

    localparam int W = 14;
    localparam int C = 16;

    logic         in_clk;
    logic         in_rst_n;
    logic         in_trigger;
    logic [W-1:0] in_cfg_amplitude;
    logic [W-1:0] in_cfg_step;
    logic [C-1:0] in_cfg_hold;
    logic [C-1:0] in_cfg_gap;
    logic [7:0]   in_cfg_repeat;
    logic         in_ready;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_busy;
    logic         out_done;
    logic         out_trig_err;

    dac_pulse_sequencer #(
        .INT_DAC_DATA_WIDTH(W),
        .INT_CNT_WIDTH(C)
    ) dut (
        .in_clk(in_clk),
        .in_rst_n(in_rst_n),
        .in_trigger(in_trigger),
        .in_cfg_amplitude(in_cfg_amplitude),
        .in_cfg_step(in_cfg_step),
        .in_cfg_hold(in_cfg_hold),
        .in_cfg_gap(in_cfg_gap),
        .in_cfg_repeat(in_cfg_repeat),
        .in_ready(in_ready),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_busy(out_busy),
        .out_done(out_done),
        .out_trig_err(out_trig_err)
    );

    initial in_clk = 1'b0;
    always #5 in_clk = ~in_clk;

    int n_cmp = 0;
    int n_bad = 0;

    int exp_q[$];
    int obs_data[$];
    bit obs_rdy[$];
    bit obs_done[$];
    bit obs_busy[$];
    bit obs_err[$];
    bit timeout;

    task automatic tick();
        @(posedge in_clk);
        #1;
    endtask

    // Whole sequence written out as a list of samples from the pulse rules.
    function automatic void build_exp(input int a, input int s, input int h,
                                      input int g, input int r);
        int se, mag, sg, n, reps;
        exp_q.delete();
        if (a == 0) begin
            exp_q.push_back(0);
            return;
        end
        se  = (s == 0) ? 1 : s;
        mag = (a < 0) ? -a : a;
        sg  = (a < 0) ? -1 : 1;
        n   = (mag + se - 1) / se;
        reps = r + 1;
`ifndef DAC_PULSE_SEQUENCER_REPEAT_EN
        reps = 1;
`endif
        for (int p = 0; p < reps; p++) begin
            if (p > 0)
                for (int i = 0; i < g; i++) exp_q.push_back(0);
            for (int i = 1; i <= n; i++)
                exp_q.push_back(sg * ((i * se < mag) ? i * se : mag));
            for (int i = 0; i < h; i++) exp_q.push_back(a);
            for (int i = 1; i <= n; i++)
                exp_q.push_back(sg * ((mag - i * se > 0) ? mag - i * se : 0));
        end
    endfunction

    task automatic rec(input bit rdy);
        obs_data.push_back(int'($signed(out_data)));
        obs_rdy.push_back(rdy);
        obs_done.push_back(out_done);
        obs_busy.push_back(out_busy);
        obs_err.push_back(out_trig_err);
    endtask

    // Triggers one sequence and records every cycle until out_done plus one.
    task automatic play(input int a, input int s, input int h, input int g,
                        input int r, input int stall_at, input int stall_len,
                        input bit rnd, input int trig_at);
        int acc, cyc, sc;
        bit rdy;
        obs_data.delete();
        obs_rdy.delete();
        obs_done.delete();
        obs_busy.delete();
        obs_err.delete();
        in_cfg_amplitude = W'(a);
        in_cfg_step      = W'(s);
        in_cfg_hold      = C'(h);
        in_cfg_gap       = C'(g);
        in_cfg_repeat    = 8'(r);
        in_trigger = 1'b1;
        in_ready   = 1'b1;
        tick();
        in_trigger       = 1'b0;
        in_cfg_amplitude = W'($urandom);
        in_cfg_step      = W'($urandom);
        in_cfg_hold      = C'($urandom);
        in_cfg_gap       = C'($urandom);
        in_cfg_repeat    = 8'($urandom);
        rec(1'b1);
        acc = 1;
        cyc = 0;
        sc  = 0;
        while (!out_done && cyc < 2000) begin
            if (acc == stall_at && sc < stall_len) begin
                rdy = 1'b0;
                sc++;
            end else if (rnd) begin
                rdy = ($urandom_range(0, 3) != 0);
            end else begin
                rdy = 1'b1;
            end
            in_ready   = rdy;
            in_trigger = (cyc == trig_at);
            tick();
            in_trigger = 1'b0;
            rec(rdy);
            if (rdy) acc++;
            cyc++;
        end
        timeout = !out_done;
        in_ready = 1'b1;
        tick();
        rec(1'b1);
    endtask

    task automatic test_reset();
        in_rst_n         = 1'b0;
        in_trigger       = 1'b1;
        in_cfg_amplitude = W'(100);
        in_cfg_step      = W'(30);
        in_ready         = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (out_data !== '0 || out_valid !== 1'b0 || out_busy !== 1'b0 ||
            out_done !== 1'b0 || out_trig_err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset: data=%0d valid=%b busy=%b done=%b err=%b, want all 0",
                     $signed(out_data), out_valid, out_busy, out_done, out_trig_err);
        end
        in_trigger = 1'b0;
        in_rst_n   = 1'b1;
        tick();
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== '0 || out_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_release: valid=%b data=%0d busy=%b, want 1 0 0",
                     out_valid, $signed(out_data), out_busy);
        end
    endtask

    task automatic test_pulses();
        int tbl [8][8];
        int k, prev, eidx;
        tbl = '{
            '{100,   30,    2, 0, 0, -1, 0, -1},
            '{-8192, 4096,  0, 0, 0, -1, 0, -1},
            '{3,     0,     0, 0, 0, -1, 0, -1},
            '{4,     4,     0, 2, 1, -1, 0, -1},
            '{100,   30,    2, 0, 0,  2, 3, -1},
            '{100,   30,    2, 0, 0, -1, 0,  3},
            '{8191,  16383, 1, 0, 0, -1, 0, -1},
            '{-8192, 16383, 0, 3, 2, -1, 0, -1}
        };
        for (int t = 0; t < 8; t++) begin
            play(tbl[t][0], tbl[t][1], tbl[t][2], tbl[t][3], tbl[t][4],
                 tbl[t][5], tbl[t][6], 1'b0, tbl[t][7]);
            build_exp(tbl[t][0], tbl[t][1], tbl[t][2], tbl[t][3], tbl[t][4]);
            eidx = (tbl[t][7] >= 0) ? tbl[t][7] + 1 : -1;
            k = 0;
            prev = 0;
            for (int i = 0; i < obs_data.size(); i++) begin
                int ed;
                bit edn, eb;
                if (i == obs_data.size() - 1) begin
                    ed = 0; edn = 1'b0; eb = 1'b0;
                end else begin
                    ed = prev; edn = 1'b0; eb = (tbl[t][0] != 0);
                    if (obs_rdy[i]) begin
                        ed  = (k < exp_q.size()) ? exp_q[k] : 0;
                        edn = (k == exp_q.size() - 1);
                        k++;
                    end
                end
                n_cmp++;
                if (obs_data[i] !== ed || obs_done[i] !== edn ||
                    obs_busy[i] !== eb || obs_err[i] !== (i == eidx)) begin
                    n_bad++;
                    $display("FAIL pulse%0d[%0d]: data=%0d done=%b busy=%b err=%b, want data=%0d done=%b busy=%b err=%b",
                             t, i, obs_data[i], obs_done[i], obs_busy[i], obs_err[i],
                             ed, edn, eb, (i == eidx));
                end
                prev = ed;
            end
            n_cmp++;
            if (timeout || k != exp_q.size() ||
                obs_data.size() - 1 != exp_q.size() + tbl[t][6]) begin
                n_bad++;
                $display("FAIL pulse%0d_len: samples=%0d cycles=%0d, want samples=%0d cycles=%0d",
                         t, k, obs_data.size() - 1, exp_q.size(),
                         exp_q.size() + tbl[t][6]);
            end
        end
    endtask

    task automatic test_no_pulse();
        in_cfg_amplitude = '0;
        in_cfg_step      = W'(7);
        in_cfg_hold      = C'(3);
        in_cfg_repeat    = 8'd0;
        in_trigger       = 1'b1;
        in_ready         = 1'b1;
        tick();
        in_trigger = 1'b0;
        n_cmp++;
        if (out_done !== 1'b1 || out_busy !== 1'b0 || out_data !== '0) begin
            n_bad++;
            $display("FAIL zero_amp: done=%b busy=%b data=%0d, want 1 0 0",
                     out_done, out_busy, $signed(out_data));
        end
        tick();
        n_cmp++;
        if (out_done !== 1'b0 || out_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL zero_amp_after: done=%b busy=%b, want 0 0", out_done, out_busy);
        end
        in_cfg_amplitude = W'(50);
        in_cfg_step      = W'(5);
        in_trigger       = 1'b1;
        in_ready         = 1'b0;
        tick();
        in_trigger = 1'b0;
        in_ready   = 1'b1;
        n_cmp++;
        if (out_busy !== 1'b0 || out_data !== '0 || out_done !== 1'b0) begin
            n_bad++;
            $display("FAIL drop_trig: busy=%b data=%0d done=%b, want 0 0 0",
                     out_busy, $signed(out_data), out_done);
        end
        tick();
        n_cmp++;
        if (out_busy !== 1'b0 || out_data !== '0) begin
            n_bad++;
            $display("FAIL drop_trig_after: busy=%b data=%0d, want 0 0",
                     out_busy, $signed(out_data));
        end
    endtask

    task automatic test_back_to_back();
        int ed [7] = '{4, 0, -1, -2, -1, 0, 0};
        bit tr [7] = '{1, 1, 1, 0, 0, 0, 0};
        bit dn [7] = '{0, 1, 0, 0, 0, 1, 0};
        bit bz [7] = '{1, 1, 1, 1, 1, 1, 0};
        bit er [7] = '{0, 1, 0, 0, 0, 0, 0};
        in_cfg_amplitude = W'(4);
        in_cfg_step      = W'(4);
        in_cfg_hold      = '0;
        in_cfg_gap       = '0;
        in_cfg_repeat    = 8'd0;
        in_ready         = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (i == 1) begin
                in_cfg_amplitude = W'(-2);
                in_cfg_step      = W'(1);
            end
            in_trigger = tr[i];
            tick();
            in_trigger = 1'b0;
            n_cmp++;
            if (int'($signed(out_data)) !== ed[i] || out_done !== dn[i] ||
                out_busy !== bz[i] || out_trig_err !== er[i]) begin
                n_bad++;
                $display("FAIL b2b[%0d]: data=%0d done=%b busy=%b err=%b, want %0d %b %b %b",
                         i, $signed(out_data), out_done, out_busy, out_trig_err,
                         ed[i], dn[i], bz[i], er[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        in_cfg_amplitude = W'(100);
        in_cfg_step      = W'(30);
        in_cfg_hold      = C'(2);
        in_cfg_repeat    = 8'd0;
        in_ready         = 1'b1;
        in_trigger       = 1'b1;
        tick();
        in_trigger = 1'b0;
        repeat (6) tick();
        n_cmp++;
        if (int'($signed(out_data)) !== 70) begin
            n_bad++;
            $display("FAIL rst_mid_pre: data=%0d, want 70", $signed(out_data));
        end
        in_rst_n = 1'b0;
        tick();
        n_cmp++;
        if (out_data !== '0 || out_valid !== 1'b0 || out_busy !== 1'b0 ||
            out_done !== 1'b0 || out_trig_err !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_mid: data=%0d valid=%b busy=%b done=%b err=%b, want all 0",
                     $signed(out_data), out_valid, out_busy, out_done, out_trig_err);
        end
        in_rst_n = 1'b1;
        tick();
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== '0 || out_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_mid_release: valid=%b data=%0d busy=%b, want 1 0 0",
                     out_valid, $signed(out_data), out_busy);
        end
        in_cfg_amplitude = W'(5);
        in_cfg_step      = W'(5);
        in_cfg_hold      = '0;
        in_trigger       = 1'b1;
        tick();
        in_trigger = 1'b0;
        n_cmp++;
        if (int'($signed(out_data)) !== 5 || out_busy !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_mid_restart: data=%0d busy=%b, want 5 1",
                     $signed(out_data), out_busy);
        end
        tick();
        n_cmp++;
        if (out_data !== '0 || out_done !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_mid_end: data=%0d done=%b, want 0 1",
                     $signed(out_data), out_done);
        end
        tick();
        n_cmp++;
        if (out_busy !== 1'b0 || out_done !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_mid_idle: busy=%b done=%b, want 0 0", out_busy, out_done);
        end
    endtask

    task automatic test_random();
        int a, s, h, g, r, mag, k, prev;
        for (int t = 0; t < 25; t++) begin
            a = int'($signed(W'($urandom)));
            if (t % 8 == 0) a = -8192;
            if (t % 8 == 5) a = 8191;
            mag = (a < 0) ? -a : a;
            if ($urandom_range(0, 3) == 0)
                s = int'($urandom_range(0, 16383));
            else
                s = mag / int'($urandom_range(1, 24));
            h = int'($urandom_range(0, 5));
            g = int'($urandom_range(0, 4));
            r = int'($urandom_range(0, 3));
            play(a, s, h, g, r, -1, 0, 1'b1, -1);
            build_exp(a, s, h, g, r);
            k = 0;
            prev = 0;
            for (int i = 0; i < obs_data.size(); i++) begin
                int ed;
                bit edn, eb;
                if (i == obs_data.size() - 1) begin
                    ed = 0; edn = 1'b0; eb = 1'b0;
                end else begin
                    ed = prev; edn = 1'b0; eb = (a != 0);
                    if (obs_rdy[i]) begin
                        ed  = (k < exp_q.size()) ? exp_q[k] : 0;
                        edn = (k == exp_q.size() - 1);
                        k++;
                    end
                end
                n_cmp++;
                if (obs_data[i] !== ed || obs_done[i] !== edn ||
                    obs_busy[i] !== eb || obs_err[i] !== 1'b0) begin
                    n_bad++;
                    $display("FAIL rand%0d[%0d] A=%0d S=%0d H=%0d: data=%0d done=%b busy=%b err=%b, want data=%0d done=%b busy=%b err=0",
                             t, i, a, s, h, obs_data[i], obs_done[i], obs_busy[i],
                             obs_err[i], ed, edn, eb);
                end
                prev = ed;
            end
            n_cmp++;
            if (timeout || k != exp_q.size()) begin
                n_bad++;
                $display("FAIL rand%0d_len: samples=%0d timeout=%b, want samples=%0d",
                         t, k, timeout, exp_q.size());
            end
        end
    endtask

    initial begin
        in_rst_n         = 1'b0;
        in_trigger       = 1'b0;
        in_cfg_amplitude = '0;
        in_cfg_step      = '0;
        in_cfg_hold      = '0;
        in_cfg_gap       = '0;
        in_cfg_repeat    = '0;
        in_ready         = 1'b1;
        timeout          = 1'b0;
        test_reset();
        test_pulses();
        test_no_pulse();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
